// File: rtl/clock_phase_gen.sv
// Multi-channel divided-clock generator with a shared programmable ratio, per-channel phase,
// rising-edge strobes and run/halt/single-step control over a master period counter.
module clock_phase_gen #(
  parameter int NUM_CH      = 4,
  parameter int CNT_W       = 4,
  parameter int DIV_DEFAULT = 4,
  parameter int START_RUN   = 1
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      run,
  input  logic                      step,
  input  logic [CNT_W-1:0]          div_in,
  input  logic [NUM_CH*CNT_W-1:0]   phase_in,
  output logic [NUM_CH-1:0]         clk_out,
  output logic [NUM_CH-1:0]         tick,
  output logic                      halted,
  output logic                      step_done,
  output logic [15:0]               period_cnt
);

  typedef enum logic [1:0] {S_RUN, S_DRAIN, S_HALT, S_STEP} state_t;
  localparam state_t RESET_STATE = (START_RUN != 0) ? S_RUN : S_HALT;

  state_t             state, state_next;
  logic [CNT_W-1:0]   cnt, cnt_next;
  logic [CNT_W-1:0]   div_r, div_next, div_clamped, half_next;
  logic               counting, wrap;
  logic [CNT_W-1:0]   ph_eff [NUM_CH];
  logic [CNT_W:0]     radd   [NUM_CH];
  logic [CNT_W:0]     resid  [NUM_CH];
  logic [NUM_CH-1:0]  clk_d, tick_d;

  // Counter advance, ratio reload and run/drain/halt/step sequencing.
  always_comb begin
    counting    = (state != S_HALT);
    wrap        = counting && (cnt == (div_r - CNT_W'(1)));
    div_clamped = (div_in < CNT_W'(2)) ? CNT_W'(2) : div_in;
    if (!counting || wrap) begin
      div_next = div_clamped;
    end else begin
      div_next = div_r;
    end
    if (!counting) begin
      cnt_next = cnt;
    end else if (wrap) begin
      cnt_next = '0;
    end else begin
      cnt_next = cnt + CNT_W'(1);
    end
    state_next = state;
    case (state)
      S_RUN: begin
        if (!run) state_next = S_DRAIN;
        else      state_next = S_RUN;
      end
      S_DRAIN: begin
        if (run)       state_next = S_RUN;
        else if (wrap) state_next = S_HALT;
        else           state_next = S_DRAIN;
      end
      S_HALT: begin
        if (run)       state_next = S_RUN;
        else if (step) state_next = S_STEP;
        else           state_next = S_HALT;
      end
      S_STEP: begin
        if (wrap) state_next = S_HALT;
        else      state_next = S_STEP;
      end
      default: state_next = RESET_STATE;
    endcase
  end

  // Per-channel output decode from the counter value the next cycle will hold.
  always_comb begin
    half_next = div_next >> 1;
    clk_d     = '0;
    tick_d    = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (phase_in[i*CNT_W +: CNT_W] < div_next) begin
        ph_eff[i] = phase_in[i*CNT_W +: CNT_W];
      end else begin
        ph_eff[i] = '0;
      end
      // add one period before subtracting the phase when the counter is behind it
      radd[i]  = (cnt_next >= ph_eff[i]) ? {(CNT_W+1){1'b0}} : {1'b0, div_next};
      resid[i] = {1'b0, cnt_next} + radd[i] - {1'b0, ph_eff[i]};
      if (state_next == S_HALT) begin
        clk_d[i]  = 1'b0;
        tick_d[i] = 1'b0;
      end else begin
        clk_d[i]  = (resid[i] < {1'b0, half_next});
        tick_d[i] = (resid[i] == {(CNT_W+1){1'b0}});
      end
    end
  end

  // State, counter and registered outputs.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= RESET_STATE;
      cnt        <= '0;
      div_r      <= CNT_W'(DIV_DEFAULT);
      clk_out    <= '0;
      tick       <= '0;
      halted     <= (START_RUN == 0);
      step_done  <= 1'b0;
      period_cnt <= 16'd0;
    end else begin
      state     <= state_next;
      cnt       <= cnt_next;
      div_r     <= div_next;
      clk_out   <= clk_d;
      tick      <= tick_d;
      halted    <= (state_next == S_HALT);
      step_done <= (state == S_STEP) && wrap;
      if (wrap) begin
        period_cnt <= period_cnt + 16'd1;
      end else begin
        period_cnt <= period_cnt;
      end
    end
  end

endmodule
